// File: rtl/ray_pkg.sv
// ray_pkg
// Shared types for the compute-array front end (pixel_dispatcher) and the
// back end (pixel collector).
//   COORD_W        coordinate / image dimension width
//   disp_state_t   dispatcher FSM states
//   pixel_job_t    one pixel job: coordinate plus SOF/EOL tags
//   idx_width()    width of a core index for a given core count
package ray_pkg;

  localparam int COORD_W = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } disp_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               sof;
    logic               eol;
  } pixel_job_t;

  // A single-core build still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_dispatcher_if.sv
// pixel_dispatcher_if
// Job handshake between the dispatcher and the compute cores.
//   core_valid  one-hot (or zero) job valid, one bit per core
//   core_ready  per-core ready to accept a job
//   x_out/y_out pixel coordinate, shared by all cores
//   sof_out     job is pixel (0,0)
//   eol_out     job is the last pixel of its line
// Modports: master = dispatcher side, slave = core side.
interface pixel_dispatcher_if #(
  parameter int NUM_CORES = 2
);
  import ray_pkg::*;

  logic [NUM_CORES-1:0] core_valid;
  logic [NUM_CORES-1:0] core_ready;
  logic [COORD_W-1:0]   x_out;
  logic [COORD_W-1:0]   y_out;
  logic                 sof_out;
  logic                 eol_out;

  modport master (
    output core_valid,
    output x_out,
    output y_out,
    output sof_out,
    output eol_out,
    input  core_ready
  );

  modport slave (
    input  core_valid,
    input  x_out,
    input  y_out,
    input  sof_out,
    input  eol_out,
    output core_ready
  );

endinterface

// File: rtl/rr_core_sel.sv
// rr_core_sel
// Round-robin core index. The dispatcher and the collector both instantiate
// this so that the job order and the drain order follow one wrap rule.
//   aclk, aresetn  clock, asynchronous active-low reset (index -> 0)
//   advance        step to the next core this cycle
//   extra_cores    active cores minus one; clamped to NUM_CORES-1
//   cur_idx        current core index (registered)
//   next_idx       index that cur_idx takes after this edge
module rr_core_sel
  import ray_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int CNT_W     = 2,
  localparam int IDX_W    = idx_width(NUM_CORES)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             advance,
  input  logic [CNT_W-1:0] extra_cores,
  output logic [IDX_W-1:0] cur_idx,
  output logic [IDX_W-1:0] next_idx
);

  logic [IDX_W-1:0] cur_reg;
  logic [IDX_W-1:0] cur_next;
  logic [IDX_W-1:0] last_idx;

  always_comb begin
    if (int'(extra_cores) >= NUM_CORES - 1) begin
      last_idx = IDX_W'(NUM_CORES - 1);
    end else begin
      last_idx = IDX_W'(extra_cores);
    end
  end

  // '>=' rather than '==': if the active count shrank between frames while
  // the index sits above the new last core, it falls back to core 0 instead
  // of running off the end.
  always_comb begin
    cur_next = cur_reg;
    if (advance) begin
      cur_next = (cur_reg >= last_idx) ? '0 : cur_reg + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cur_reg <= '0;
    end else begin
      cur_reg <= cur_next;
    end
  end

  assign cur_idx  = cur_reg;
  assign next_idx = cur_next;

endmodule

// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher
// Walks an image_width x image_height frame in raster order and hands one
// pixel job per accept to the compute cores in strict round-robin order.
//   aclk, aresetn      clock, asynchronous active-low reset
//   start              frame start, sampled only in IDLE
//   image_width/height frame size, latched at start
//   no_of_extra_cores  active cores minus one, latched at start
//   jobs               job handshake (master): core_valid/core_ready,
//                      x_out, y_out, sof_out, eol_out
//   busy               frame in progress (ISSUE or DONE)
//   frame_done         one-cycle pulse after the last job is accepted
// Every output comes straight from a register; core_ready only steers
// the next state.
module pixel_dispatcher
  import ray_pkg::*;
#(
  parameter int NUM_CORES = 2
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start,
  input  logic [COORD_W-1:0] image_width,
  input  logic [COORD_W-1:0] image_height,
  input  logic [1:0]         no_of_extra_cores,
  pixel_dispatcher_if.master jobs,
  output logic               busy,
  output logic               frame_done
);

  localparam int IDX_W = idx_width(NUM_CORES);

  disp_state_t          state_reg;
  pixel_job_t           job_reg;
  logic [COORD_W-1:0]   width_m1_reg;
  logic [COORD_W-1:0]   height_m1_reg;
  logic [1:0]           extra_reg;
  logic [NUM_CORES-1:0] core_valid_reg;
  logic                 busy_reg;
  logic                 frame_done_reg;

  logic                 accept;
  logic [IDX_W-1:0]     cur_idx;
  logic [IDX_W-1:0]     next_idx;
  logic [NUM_CORES-1:0] cur_onehot;
  logic [NUM_CORES-1:0] next_onehot;
  logic                 last_x;
  logic                 last_y;
  logic [COORD_W-1:0]   x_next;
  logic [COORD_W-1:0]   y_next;

  // core_valid_reg is one-hot on the current core, so this is exactly
  // "selected core is ready"; other cores' ready bits are masked out.
  assign accept = (state_reg == ISSUE) && |(core_valid_reg & jobs.core_ready);

  rr_core_sel #(
    .NUM_CORES (NUM_CORES),
    .CNT_W     (2)
  ) u_rr (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .advance     (accept),
    .extra_cores (extra_reg),
    .cur_idx     (cur_idx),
    .next_idx    (next_idx)
  );

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_sel
    assign cur_onehot[gi]  = (cur_idx == IDX_W'(gi));
    assign next_onehot[gi] = (next_idx == IDX_W'(gi));
  end

  assign last_x = (job_reg.x == width_m1_reg);
  assign last_y = (job_reg.y == height_m1_reg);
  assign x_next = last_x ? '0 : job_reg.x + 1'b1;
  assign y_next = last_x ? job_reg.y + 1'b1 : job_reg.y;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      job_reg        <= '0;
      width_m1_reg   <= '0;
      height_m1_reg  <= '0;
      extra_reg      <= '0;
      core_valid_reg <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          busy_reg       <= 1'b0;
          core_valid_reg <= '0;
          if (start) begin
            width_m1_reg  <= image_width - 1'b1;
            height_m1_reg <= image_height - 1'b1;
            extra_reg     <= no_of_extra_cores;
            busy_reg      <= 1'b1;
            if (image_width == '0 || image_height == '0) begin
              state_reg      <= DONE;
              frame_done_reg <= 1'b1;
              job_reg        <= '0;
            end else begin
              // The index is deliberately not cleared here: it carries over
              // from the previous frame to stay in step with the collector.
              state_reg      <= ISSUE;
              core_valid_reg <= cur_onehot;
              job_reg.x      <= '0;
              job_reg.y      <= '0;
              job_reg.sof    <= 1'b1;
              job_reg.eol    <= (image_width == COORD_W'(1));
            end
          end
        end

        ISSUE: begin
          if (accept) begin
            if (last_x && last_y) begin
              state_reg      <= DONE;
              frame_done_reg <= 1'b1;
              core_valid_reg <= '0;
              job_reg        <= '0;
            end else begin
              core_valid_reg <= next_onehot;
              job_reg.x      <= x_next;
              job_reg.y      <= y_next;
              // Only (0,0) carries SOF and it never recurs within a frame.
              job_reg.sof    <= 1'b0;
              job_reg.eol    <= (x_next == width_m1_reg);
            end
          end
        end

        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg      <= IDLE;
          core_valid_reg <= '0;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign jobs.core_valid = core_valid_reg;
  assign jobs.x_out      = job_reg.x;
  assign jobs.y_out      = job_reg.y;
  assign jobs.sof_out    = job_reg.sof;
  assign jobs.eol_out    = job_reg.eol;
  assign busy            = busy_reg;
  assign frame_done      = frame_done_reg;

endmodule
